// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types, constants and helpers for the 7-segment scan controller.
package seg_pkg;

  localparam int SEG_DIGITS_MAX = 8;

  // Anodes are active-low, so all ones means every digit dark.
  localparam logic [SEG_DIGITS_MAX-1:0] AN_OFF = {SEG_DIGITS_MAX{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } seg_state_e;

  // Bit k is set when nibbles k..digits-1 of value are all zero.
  function automatic logic [SEG_DIGITS_MAX-1:0] lz_mask(input logic [31:0] value,
                                                        input int          digits);
    logic                      zero_above;
    logic [SEG_DIGITS_MAX-1:0] mask;
    zero_above = 1'b1;
    mask       = {SEG_DIGITS_MAX{1'b0}};
    for (int k = SEG_DIGITS_MAX - 1; k >= 0; k--) begin
      if (k < digits) begin
        zero_above = zero_above & (value[4*k +: 4] == 4'h0);
        mask[k]    = zero_above;
      end else begin
        mask[k]    = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-value handshake between the register-tap logic and the scanner.
interface seg_scan_ctrl_if;
  logic [31:0] value_in;
  logic        value_valid;
  logic        value_ready;

  modport master (output value_in, output value_valid, input value_ready);
  modport slave  (input value_in, input value_valid, output value_ready);
endinterface

// File: rtl/seg_scan_ctrl_scan_timer.sv
// Loadable down-counter; o_tc is high while the count sits at zero.
module scan_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != {CW{1'b0}}) begin
      r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tc = (r_cnt == {CW{1'b0}});

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner: one shared decoder nibble, dead time
// between digits, double-buffered value so a frame never tears.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DWELL  = 50000,
  parameter int BLANK  = 16
) (
  input  logic              slowClk,
  input  logic              reset,
  seg_scan_ctrl_if.slave    vif,
  input  logic [DIGITS-1:0] digit_en,
  input  logic              lz_blank,
  output logic [3:0]        reg_hex,
  output logic [DIGITS-1:0] an,
  output logic              frame_done
);

  localparam int IDXW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]     BLANK_LD = CW'(BLANK - 1);
  localparam logic [CW-1:0]     DWELL_LD = CW'(DWELL - 1);
  localparam logic [IDXW-1:0]   IDX_LAST = IDXW'(DIGITS - 1);
  localparam logic [IDXW-1:0]   IDX_ZERO = {IDXW{1'b0}};
  localparam logic [DIGITS-1:0] AN_OFF_D = AN_OFF[DIGITS-1:0];

  seg_state_e r_state, w_next_state;
  logic [31:0]       r_disp, r_pend, w_next_disp;
  logic              r_pend_full;
  logic [IDXW-1:0]   r_idx, w_next_idx;
  logic              w_accept, w_copy, w_load, w_tc, w_frame_end;
  logic [CW-1:0]     w_load_val;
  logic [3:0]        w_nib [DIGITS];
  logic [SEG_DIGITS_MAX-1:0] w_lz_full;
  logic [DIGITS-1:0] w_lz, w_an_next;
  logic [DIGITS-1:0] r_an;
  logic [3:0]        r_reg_hex;
  logic              r_frame_done;

  assign vif.value_ready = ~r_pend_full;
  assign w_accept        = vif.value_valid & ~r_pend_full;

  scan_timer #(.CW(CW)) u_timer (
    .clk        (slowClk),
    .rst_n      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  // Next-state logic: sequence BLANK/SHOW slots and decide when disp reloads.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_copy       = 1'b0;
    w_load       = 1'b0;
    w_load_val   = {CW{1'b0}};
    w_frame_end  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend_full) begin
          w_next_state = ST_BLANK;
          w_copy       = 1'b1;
          w_next_idx   = IDX_ZERO;
          w_load       = 1'b1;
          w_load_val   = BLANK_LD;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_BLANK: begin
        if (w_tc) begin
          w_next_state = ST_SHOW;
          w_load       = 1'b1;
          w_load_val   = DWELL_LD;
        end else begin
          w_next_state = ST_BLANK;
        end
      end
      ST_SHOW: begin
        if (w_tc) begin
          w_next_state = ST_BLANK;
          w_load       = 1'b1;
          w_load_val   = BLANK_LD;
          if (r_idx == IDX_LAST) begin
            w_frame_end = 1'b1;
            w_copy      = r_pend_full;
            w_next_idx  = IDX_ZERO;
          end else begin
            w_next_idx  = r_idx + {{(IDXW-1){1'b0}}, 1'b1};
          end
        end else begin
          w_next_state = ST_SHOW;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_idx   = IDX_ZERO;
      end
    endcase
  end

  assign w_next_disp = w_copy ? r_pend : r_disp;
  assign w_lz_full   = lz_mask(w_next_disp, DIGITS);
  assign w_lz        = w_lz_full[DIGITS-1:0];

  // Split the upcoming display value into per-digit nibbles.
  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      w_nib[k] = w_next_disp[4*k +: 4];
    end
  end

  // Anode pattern for the coming cycle: one digit low only while showing a visible digit.
  always_comb begin
    w_an_next = AN_OFF_D;
    if ((w_next_state == ST_SHOW) && digit_en[w_next_idx] &&
        !(lz_blank && (w_next_idx != IDX_ZERO) && w_lz[w_next_idx])) begin
      w_an_next = AN_OFF_D & ~(DIGITS'(1) << w_next_idx);
    end else begin
      w_an_next = AN_OFF_D;
    end
  end

  // State register.
  always_ff @(posedge slowClk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Value buffers and digit index: pend fills on accept, disp reloads only on copy.
  always_ff @(posedge slowClk or negedge reset) begin
    if (!reset) begin
      r_disp      <= 32'h0000_0000;
      r_pend      <= 32'h0000_0000;
      r_pend_full <= 1'b0;
      r_idx       <= IDX_ZERO;
    end else begin
      if (w_copy) begin
        r_disp <= r_pend;
      end
      if (w_accept) begin
        r_pend <= vif.value_in;
      end
      r_pend_full <= w_accept | (r_pend_full & ~w_copy);
      r_idx       <= w_next_idx;
    end
  end

  // Registered display outputs; anodes go dark the instant reset asserts.
  always_ff @(posedge slowClk or negedge reset) begin
    if (!reset) begin
      r_an         <= AN_OFF_D;
      r_reg_hex    <= 4'h0;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_next;
      r_reg_hex    <= w_nib[w_next_idx];
      r_frame_done <= w_frame_end;
    end
  end

  assign an         = r_an;
  assign reg_hex    = r_reg_hex;
  assign frame_done = r_frame_done;

endmodule
